// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types and helpers for the sub-word handshake data memory.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Access size encoding as carried on req_size; 2'd3 is the illegal size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  // Request lifecycle: accept -> wait out latency -> hold response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Latency counter width; covers LATENCY up to 15.
  localparam int unsigned CNT_W = 4;

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] nbytes(input size_e size);
    case (size)
      SZ_BYTE: nbytes = 3'd1;
      SZ_HALF: nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_load_align
// Brief    : Selects the addressed byte/half/word out of a big-endian aligned
//            word and sign- or zero-extends it to 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,      // byte at aligned address in [31:24]
  input  logic [1:0]  addr_lo_i,   // byte offset within the word
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Big-endian lane pick followed by size-dependent extension.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    data_o   = 32'h0000_0000;

    case (addr_lo_i)
      2'd0:    byte_sel = word_i[31:24];
      2'd1:    byte_sel = word_i[23:16];
      2'd2:    byte_sel = word_i[15:8];
      default: byte_sel = word_i[7:0];
    endcase

    half_sel = addr_lo_i[1] ? word_i[15:0] : word_i[31:16];

    case (size_e'(size_i))
      SZ_BYTE: data_o = unsigned_i ? {24'h000000, byte_sel}
                                   : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = unsigned_i ? {16'h0000, half_sel}
                                   : {{16{half_sel[15]}}, half_sel};
      SZ_WORD: data_o = word_i;
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_subword_hs.sv
`default_nettype none
// ============================================================================
// Module   : mem_subword_hs
// Brief    : Big-endian byte-addressed data memory with byte/half/word
//            access, configurable latency, fault detection and a
//            valid/ready request/response handshake (one outstanding).
// Revision : 1.0 - initial release
// ============================================================================
module mem_subword_hs
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned START     = 0,
  parameter int unsigned TOP       = 65535,
  parameter int unsigned LATENCY   = 2,      // legal 1..15
  parameter int unsigned HAS_INIT  = 0,
  parameter string       INIT_FILE = ""
)(
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault
);

  localparam int unsigned       c_DEPTH     = TOP - START + 1;
  localparam int unsigned       c_IDX_W     = $clog2(c_DEPTH);
  // One extra bit so address-minus-START exposes a borrow and
  // address-plus-size cannot wrap.
  localparam int                c_EXT_W     = ADDR_W + 1;
  localparam logic [c_EXT_W-1:0] c_START_EXT = c_EXT_W'(START);
  localparam logic [c_EXT_W-1:0] c_SPAN_EXT  = c_EXT_W'(TOP - START);
  localparam logic [c_EXT_W-1:0] c_DEPTH_EXT = c_EXT_W'(c_DEPTH);
  localparam logic [CNT_W-1:0]  c_CNT_INIT  = CNT_W'(LATENCY - 1);

  // --------------------------------------------------------------------------
  // State and latched request
  // --------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               commit;

  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [31:0]        wdata_q;
  logic               fault_q;

  logic [31:0]        resp_rdata_q;
  logic               resp_fault_q;

  logic [7:0]         mem_q    [0:c_DEPTH-1];
  logic [7:0]         init_img [0:c_DEPTH-1];

  // --------------------------------------------------------------------------
  // Fault check on the incoming request
  // --------------------------------------------------------------------------
  logic [c_EXT_W-1:0] req_off;
  logic [c_EXT_W-1:0] req_last;
  logic               req_below;
  logic               req_above;
  logic               req_misalign;
  logic               req_fault;

  assign req_off      = {1'b0, req_addr} - c_START_EXT;
  assign req_last     = req_off + c_EXT_W'(nbytes(size_e'(req_size))) - c_EXT_W'(1);
  assign req_below    = req_off[c_EXT_W-1];
  assign req_above    = req_last > c_SPAN_EXT;
  assign req_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign req_fault    = (req_size == SZ_ILLEGAL) || req_misalign ||
                        req_below || req_above;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, handshake outputs and the commit strobe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    commit     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = BUSY;
          cnt_d   = c_CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the request fields and its fault verdict on acceptance.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else if (req_ready && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata;
      fault_q <= req_fault;
    end
  end

  // --------------------------------------------------------------------------
  // Storage read path: four big-endian bytes of the aligned word
  // --------------------------------------------------------------------------
  logic [c_EXT_W-1:0] base_off;
  logic [31:0]        rd_word;
  logic [31:0]        load_data;

  assign base_off = {1'b0, addr_q[ADDR_W-1:2], 2'b00} - c_START_EXT;

  for (genvar k = 0; k < 4; k++) begin : g_rd_lane
    logic [c_EXT_W-1:0] lane_off;
    assign lane_off = base_off + c_EXT_W'(k);
    // Lanes outside the storage window (unaligned START/TOP) read as zero.
    assign rd_word[31-8*k -: 8] = (lane_off < c_DEPTH_EXT)
                                  ? mem_q[lane_off[c_IDX_W-1:0]] : 8'h00;
  end

  mem_load_align u_load_align (
    .word_i     (rd_word),
    .addr_lo_i  (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  // --------------------------------------------------------------------------
  // Storage write path
  // --------------------------------------------------------------------------
  logic [c_EXT_W-1:0] st_off;
  logic [c_IDX_W-1:0] st_idx0, st_idx1, st_idx2, st_idx3;
  logic               unused_st_hi;

  assign st_off       = {1'b0, addr_q} - c_START_EXT;
  assign st_idx0      = st_off[c_IDX_W-1:0];
  assign st_idx1      = st_idx0 + c_IDX_W'(1);
  assign st_idx2      = st_idx0 + c_IDX_W'(2);
  assign st_idx3      = st_idx0 + c_IDX_W'(3);
  assign unused_st_hi = ^st_off[c_EXT_W-1:c_IDX_W];

  // Reset image: all zeros.
  assign init_img = '{default: 8'h00};

  // Reinitialise while reset is low; otherwise write the store lanes of a
  // clean commit.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_q <= init_img;
    end else if (commit && we_q && !fault_q) begin
      case (size_q)
        SZ_BYTE: begin
          mem_q[st_idx0] <= wdata_q[7:0];
        end
        SZ_HALF: begin
          mem_q[st_idx0] <= wdata_q[15:8];
          mem_q[st_idx1] <= wdata_q[7:0];
        end
        default: begin
          mem_q[st_idx0] <= wdata_q[31:24];
          mem_q[st_idx1] <= wdata_q[23:16];
          mem_q[st_idx2] <= wdata_q[15:8];
          mem_q[st_idx3] <= wdata_q[7:0];
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Response registers: loaded at the commit edge, held through RESP
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      resp_rdata_q <= 32'h0;
      resp_fault_q <= 1'b0;
    end else if (commit) begin
      resp_fault_q <= fault_q;
      resp_rdata_q <= (we_q || fault_q) ? 32'h0 : load_data;
    end
  end

  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_subword_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_subword_hs
// Brief    : Self-checking bench for mem_subword_hs with a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_subword_hs;

  localparam int    LAT    = 2;
  localparam longint MSTART = 0;
  localparam longint MTOP   = 65535;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  mem_subword_hs #(
    .ADDR_W    (32),
    .START     (0),
    .TOP       (65535),
    .LATENCY   (LAT),
    .HAS_INIT  (0),
    .INIT_FILE ("")
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mm [0:65535];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  function automatic void note_fail(input string name);
    n_checks++;
    $display("FAIL %s: got timeout/unexpected event, expected none", name);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 65536; i++) mm[i] = 8'h00;
  endfunction

  // Architectural model: byte array, big-endian, plain arithmetic.
  function automatic void model_access(input logic we, input logic [31:0] addr,
                                       input logic [1:0] size, input logic uns,
                                       input logic [31:0] wdata,
                                       output logic [31:0] rdata,
                                       output logic fault);
    longint a;
    int n;
    logic [31:0] v;
    a = longint'(addr);
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    fault = (size == 2'd3) || ((a % n) != 0) || (a < MSTART) || (a + n - 1 > MTOP);
    rdata = 32'h0;
    if (!fault) begin
      if (we) begin
        for (int i = 0; i < n; i++)
          mm[int'(a - MSTART) + i] = 8'(wdata >> (8 * (n - 1 - i)));
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(mm[int'(a - MSTART) + i]);
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        rdata = v;
      end
    end
  endfunction

  // Compare process: every cycle a response is presented it must match the
  // model, and no new request may be acceptable.
  always @(negedge clk) begin
    if (rst_b === 1'b1 && resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        note_fail("spurious_resp_valid");
      end else begin
        check("resp_rdata", resp_rdata, exp_q[0].rdata);
        check("resp_fault", 32'(resp_fault), 32'(exp_q[0].fault));
      end
      check("req_ready_while_resp", 32'(req_ready), 32'd0);
    end
  end

  task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata, input int hold,
                      input logic conc, output logic [31:0] got, output logic got_f);
    exp_t e;
    int waited;
    got   = 32'h0;
    got_f = 1'b0;
    @(negedge clk);
    req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata; req_valid = 1'b1;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      note_fail("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_access(we, addr, size, uns, wdata, e.rdata, e.fault);
    exp_q.push_back(e);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      check("resp_valid_latency", 32'(resp_valid), 32'(k == LAT));
    end
    waited = 0;
    while (resp_valid !== 1'b1 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (resp_valid !== 1'b1) begin
      note_fail("resp_timeout");
      exp_q.delete();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (conc) begin
        req_we = 1'b0; req_addr = 32'h100; req_size = 2'd2;
        req_unsigned = 1'b0; req_valid = 1'b1;
      end
    end
    @(negedge clk);
    got   = resp_rdata;
    got_f = resp_fault;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check("resp_valid_after_hs", 32'(resp_valid), 32'd0);
    check("req_ready_after_hs", 32'(req_ready), 32'd1);
  endtask

  // One access with literal expectations that pin both DUT and model.
  task automatic op(input string name, input logic we, input logic [31:0] addr,
                    input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                    input logic [31:0] exp_rd, input logic exp_f);
    logic [31:0] got;
    logic        got_f;
    xact(we, addr, size, uns, wdata, 0, 1'b0, got, got_f);
    check({name, "_rdata"}, got, exp_rd);
    check({name, "_fault"}, 32'(got_f), 32'(exp_f));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] got;
    logic        got_f;
    model_clear();

    // Reset state.
    #3 rst_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata,      32'h0);
    check("rst_resp_fault", 32'(resp_fault), 32'd0);
    rst_b = 1'b1;

    // 1: word store/load.
    op("sw_100",   1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0);
    op("lw_100",   1'b0, 32'h100, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0);
    // 2: sub-word loads with extension.
    op("lb_101",   1'b0, 32'h101, 2'd0, 1'b0, 32'h0, 32'hFFFFFFAD, 1'b0);
    op("lbu_101",  1'b0, 32'h101, 2'd0, 1'b1, 32'h0, 32'h000000AD, 1'b0);
    op("lh_102",   1'b0, 32'h102, 2'd1, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b0);
    op("lhu_102",  1'b0, 32'h102, 2'd1, 1'b1, 32'h0, 32'h0000BEEF, 1'b0);
    op("lw_uns",   1'b0, 32'h100, 2'd2, 1'b1, 32'h0, 32'hDEADBEEF, 1'b0);
    // 3: sub-word stores leave other lanes intact.
    op("sb_103",   1'b1, 32'h103, 2'd0, 1'b0, 32'hFFFFFF55, 32'h0, 1'b0);
    op("sh_100",   1'b1, 32'h100, 2'd1, 1'b0, 32'hABCD1234, 32'h0, 1'b0);
    op("lw_mix",   1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 32'h1234BE55, 1'b0);
    // 4: faults.
    op("lw_mis",   1'b0, 32'h102, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    op("sh_mis",   1'b1, 32'h101, 2'd1, 1'b0, 32'h0000FFFF, 32'h0, 1'b1);
    op("lw_top1",  1'b0, 32'hFFFE, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    op("sz3",      1'b0, 32'h100, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1);
    op("lw_oor",   1'b0, 32'h10000, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    op("lh_ffff",  1'b0, 32'hFFFF, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1);
    op("sw_oor",   1'b1, 32'h10000, 2'd2, 1'b0, 32'h11111111, 32'h0, 1'b1);
    op("lw_after", 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 32'h1234BE55, 1'b0);
    // Upper boundary, in range.
    op("sw_fffc",  1'b1, 32'hFFFC, 2'd2, 1'b0, 32'h89ABCDEF, 32'h0, 1'b0);
    op("lhu_fffe", 1'b0, 32'hFFFE, 2'd1, 1'b1, 32'h0, 32'h0000CDEF, 1'b0);
    op("lb_fffc",  1'b0, 32'hFFFC, 2'd0, 1'b0, 32'h0, 32'hFFFFFF89, 1'b0);
    op("lbu_ffff", 1'b0, 32'hFFFF, 2'd0, 1'b1, 32'h0, 32'h000000EF, 1'b0);

    // 5: backpressure with a competing request held during RESP.
    xact(1'b0, 32'h102, 2'd1, 1'b1, 32'h0, 5, 1'b1, got, got_f);
    check("bp_rdata", got, 32'h0000BE55);
    check("bp_fault", 32'(got_f), 32'd0);
    xact(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 0, 1'b0, got, got_f);
    check("bp_next_rdata", got, 32'h1234BE55);

    // 6: reset between accept and commit aborts the store.
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h200; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    check("mid_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_b = 1'b0;
    exp_q.delete();
    model_clear();
    #1;
    check("mid_rst_req_ready",  32'(req_ready),  32'd1);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_resp", 32'(resp_valid), 32'd0);
    end
    op("lw_200",   1'b0, 32'h200, 2'd2, 1'b0, 32'h0, 32'h00000000, 1'b0);
    op("lw_100_z", 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 32'h00000000, 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
